pwr_seq_ctrl: RTL and testbench

- Parametrised power-rail sequencer and reset generator for detector front-end supplies.
- Brings up NUM_STEPS rails in order with a per-step dwell, releases system reset, and pulses the ROIC reset.
- Powers rails down in reverse order on request. Optionally monitors per-rail power-good and performs an emergency shutdown on failure.
- Sits between the host/register command level and the board supply enables, replacing the fixed six-step init controller.

---
 rtl/pwr_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - power-rail sequencer and reset generator
// Define PWR_SEQ_PG_MONITOR_EN to add the power-good monitor and FAULT shutdown.
module pwr_seq_ctrl #(
  parameter int          NUM_STEPS     = 6,
  parameter int          CNT_W         = 25,
  parameter int unsigned INIT_DLY      = 1000,
  parameter int unsigned LONG_DLY      = 20000,
  parameter int          LONG_STEP     = 4,
  parameter int          RST_PULSE_LEN = 4,
  localparam int         IDX_W         = $clog2(NUM_STEPS)
) (
  input  logic                 fsm_clk,
  input  logic                 rst_n,
  input  logic                 pwr_on_req,
  input  logic [NUM_STEPS-1:0] pg_in,
  input  logic                 fault_clr,
  output logic [NUM_STEPS-1:0] rail_en,
  output logic                 init_rst,
  output logic                 roic_reset,
  output logic                 seq_on,
  output logic                 seq_busy,
  output logic                 fault,
  output logic [IDX_W-1:0]     fault_step
);

  localparam int PW = $clog2(RST_PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] INIT_END = CNT_W'(INIT_DLY - 1);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_DLY - 1);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_STEPS - 1);

  if ((longint'(INIT_DLY) >> CNT_W) != 0 || (longint'(LONG_DLY) >> CNT_W) != 0
      || INIT_DLY < 1 || LONG_DLY < 1) begin : g_dly_check
    $error("pwr_seq_ctrl: dwell values must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [2:0] {OFF, UP, ON, DOWN, FAULT} state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d, fstep_d;
  logic [CNT_W-1:0]      cnt, cnt_d, up_end;
  logic [NUM_STEPS-1:0]  rail_d;
  logic [PW-1:0]         rcnt, rcnt_d;
  logic                  init_rst_d, roic_d, fault_d, on_entry;
  logic                  req_meta, req_s;

  function automatic logic [NUM_STEPS-1:0] therm(input int n);
    logic [NUM_STEPS-1:0] m;
    for (int k = 0; k < NUM_STEPS; k++) m[k] = (k < n);
    return m;
  endfunction

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= pwr_on_req;
      req_s    <= req_meta;
    end
  end

`ifdef PWR_SEQ_PG_MONITOR_EN
  logic [NUM_STEPS-1:0] pg_meta, pg_s;
  logic [IDX_W-1:0]     pg_low;

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_meta <= '0;
      pg_s    <= '0;
    end else begin
      pg_meta <= pg_in;
      pg_s    <= pg_meta;
    end
  end

  always_comb begin
    pg_low = '0;
    for (int k = NUM_STEPS - 1; k >= 0; k--) if (!pg_s[k]) pg_low = IDX_W'(k);
  end
`else
  logic unused_pg;
  assign unused_pg = ^pg_in;
`endif

  assign up_end = (int'(idx) == LONG_STEP) ? LONG_END : INIT_END;

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    rail_d     = rail_en;
    init_rst_d = init_rst;
    fault_d    = fault;
    fstep_d    = fault_step;
    on_entry   = 1'b0;
    case (state)
      OFF: if (req_s) begin
        state_d = UP;
        idx_d   = '0;
        cnt_d   = '0;
        rail_d  = therm(1);
      end
      UP: if (!req_s) begin
        state_d = DOWN;
        cnt_d   = '0;
        rail_d  = therm(int'(idx));
      end else if (cnt == up_end) begin
`ifdef PWR_SEQ_PG_MONITOR_EN
        if (!pg_s[idx]) begin
          state_d = FAULT;
          rail_d  = '0;
          fault_d = 1'b1;
          fstep_d = idx;
        end else
`endif
        if (idx == LAST) begin
          state_d    = ON;
          on_entry   = 1'b1;
          init_rst_d = 1'b0;
        end else begin
          idx_d  = idx + 1'b1;
          cnt_d  = '0;
          rail_d = therm(int'(idx) + 2);
        end
      end
      ON: begin
`ifdef PWR_SEQ_PG_MONITOR_EN
        if (pg_s != {NUM_STEPS{1'b1}}) begin
          state_d = FAULT;
          rail_d  = '0;
          fault_d = 1'b1;
          fstep_d = pg_low;
        end else
`endif
        if (!req_s) begin
          state_d = DOWN;
          idx_d   = LAST;
          cnt_d   = '0;
          rail_d  = therm(int'(LAST));
        end
      end
      DOWN: if (cnt == INIT_END) begin
        if (idx == '0) begin
          state_d = OFF;
        end else begin
          idx_d  = idx - 1'b1;
          cnt_d  = '0;
          rail_d = therm(int'(idx) - 1);
        end
      end
      FAULT: if (fault_clr && !req_s) begin
        state_d = OFF;
        fault_d = 1'b0;
      end
      default: state_d = OFF;
    endcase
  end

  // The ROIC pulse runs off its own counter so leaving ON never truncates it.
  always_comb begin
    roic_d = roic_reset;
    rcnt_d = rcnt;
    if (on_entry) begin
      roic_d = 1'b1;
      rcnt_d = PW'(RST_PULSE_LEN - 1);
    end else if (roic_reset) begin
      if (rcnt == '0) roic_d = 1'b0;
      else            rcnt_d = rcnt - 1'b1;
    end
  end

  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      rail_en    <= '0;
      init_rst   <= 1'b1;
      roic_reset <= 1'b0;
      rcnt       <= '0;
      seq_on     <= 1'b0;
      seq_busy   <= 1'b0;
      fault      <= 1'b0;
      fault_step <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      rail_en    <= rail_d;
      init_rst   <= init_rst_d;
      roic_reset <= roic_d;
      rcnt       <= rcnt_d;
      seq_on     <= (state_d == ON);
      seq_busy   <= (state_d == UP) || (state_d == DOWN);
      fault      <= fault_d;
      fault_step <= fstep_d;
    end
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed self-checking bench for pwr_seq_ctrl
module tb_pwr_seq_ctrl;

  logic       fsm_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwr_on_req = 1'b0;
  logic [2:0] pg_in = 3'b111;
  logic       fault_clr = 1'b0;
  logic [2:0] rail_en;
  logic       init_rst, roic_reset, seq_on, seq_busy, fault;
  logic [1:0] fault_step;
  int         errors = 0;
  int         checks = 0;

  pwr_seq_ctrl #(
    .NUM_STEPS(3), .CNT_W(25), .INIT_DLY(4), .LONG_DLY(10),
    .LONG_STEP(1), .RST_PULSE_LEN(2)
  ) dut (
    .fsm_clk(fsm_clk), .rst_n(rst_n), .pwr_on_req(pwr_on_req), .pg_in(pg_in),
    .fault_clr(fault_clr), .rail_en(rail_en), .init_rst(init_rst),
    .roic_reset(roic_reset), .seq_on(seq_on), .seq_busy(seq_busy),
    .fault(fault), .fault_step(fault_step)
  );

  always #5 fsm_clk = ~fsm_clk;

  task automatic advance(input int n);
    repeat (n) @(negedge fsm_clk);
  endtask

  task automatic test_reset;
    advance(2);
    checks++; if (rail_en !== 3'b000) begin errors++; $display("FAIL reset_rail got=%b exp=000", rail_en); end
    checks++; if (init_rst !== 1'b1) begin errors++; $display("FAIL reset_init_rst got=%b exp=1", init_rst); end
    checks++; if ({roic_reset, seq_on, seq_busy, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {roic_reset, seq_on, seq_busy, fault}); end
    checks++; if (fault_step !== 2'd0) begin errors++; $display("FAIL reset_fault_step got=%0d exp=0", fault_step); end
    rst_n = 1'b1;
  endtask

  task automatic test_power_up;
    pwr_on_req = 1'b1;
    advance(2);
    checks++; if (rail_en !== 3'b000) begin errors++; $display("FAIL up_e2_rail got=%b exp=000", rail_en); end
    advance(1);
    checks++; if (rail_en !== 3'b001 || seq_busy !== 1'b1) begin errors++; $display("FAIL up_e3 got rail=%b busy=%b exp 001/1", rail_en, seq_busy); end
    advance(3);
    checks++; if (rail_en !== 3'b001) begin errors++; $display("FAIL up_e6_rail got=%b exp=001", rail_en); end
    advance(1);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL up_e7_rail got=%b exp=011", rail_en); end
    advance(9);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL up_e16_rail got=%b exp=011", rail_en); end
    advance(1);
    checks++; if (rail_en !== 3'b111) begin errors++; $display("FAIL up_e17_rail got=%b exp=111", rail_en); end
    advance(3);
    checks++; if (seq_on !== 1'b0 || init_rst !== 1'b1) begin errors++; $display("FAIL up_e20 got on=%b init=%b exp 0/1", seq_on, init_rst); end
    advance(1);
    checks++; if ({seq_on, init_rst, roic_reset, seq_busy} !== 4'b1010) begin errors++; $display("FAIL up_e21 got on/init/roic/busy=%b exp=1010", {seq_on, init_rst, roic_reset, seq_busy}); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL up_fault got=%b exp=0", fault); end
    advance(1);
    checks++; if (roic_reset !== 1'b1) begin errors++; $display("FAIL up_e22_roic got=%b exp=1", roic_reset); end
    advance(1);
    checks++; if (roic_reset !== 1'b0 || seq_on !== 1'b1) begin errors++; $display("FAIL up_e23 got roic=%b on=%b exp 0/1", roic_reset, seq_on); end
  endtask

  task automatic test_power_down;
    pwr_on_req = 1'b0;
    advance(2);
    checks++; if (rail_en !== 3'b111 || seq_on !== 1'b1) begin errors++; $display("FAIL dn_e2 got rail=%b on=%b exp 111/1", rail_en, seq_on); end
    advance(1);
    checks++; if ({rail_en, seq_busy, seq_on} !== 5'b01110) begin errors++; $display("FAIL dn_e3 got rail/busy/on=%b exp=01110", {rail_en, seq_busy, seq_on}); end
    advance(4);
    checks++; if (rail_en !== 3'b001) begin errors++; $display("FAIL dn_e7_rail got=%b exp=001", rail_en); end
    advance(4);
    checks++; if (rail_en !== 3'b000 || seq_busy !== 1'b1) begin errors++; $display("FAIL dn_e11 got rail=%b busy=%b exp 000/1", rail_en, seq_busy); end
    advance(3);
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL dn_e14_busy got=%b exp=1", seq_busy); end
    advance(1);
    checks++; if (seq_busy !== 1'b0 || init_rst !== 1'b0) begin errors++; $display("FAIL dn_e15 got busy=%b init=%b exp 0/0", seq_busy, init_rst); end
  endtask

  task automatic test_abort;
    logic roic_hi;
    pwr_on_req = 1'b1;
    advance(7);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL ab_pre_rail got=%b exp=011", rail_en); end
    advance(2);
    pwr_on_req = 1'b0;
    roic_hi = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      advance(1);
      roic_hi = roic_hi | roic_reset;
      if (i == 3) begin
        checks++; if (rail_en !== 3'b001 || seq_busy !== 1'b1) begin errors++; $display("FAIL ab_down got rail=%b busy=%b exp 001/1", rail_en, seq_busy); end
      end
      if (i == 6) begin
        checks++; if (rail_en !== 3'b001) begin errors++; $display("FAIL ab_hold got=%b exp=001", rail_en); end
      end
      if (i == 7) begin
        checks++; if (rail_en !== 3'b000) begin errors++; $display("FAIL ab_zero got=%b exp=000", rail_en); end
      end
      if (i == 10) begin
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL ab_busy got=%b exp=1", seq_busy); end
      end
      if (i == 11) begin
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL ab_off got=%b exp=0", seq_busy); end
      end
    end
    checks++; if (roic_hi !== 1'b0 || seq_on !== 1'b0) begin errors++; $display("FAIL ab_roic got roic_seen=%b on=%b exp 0/0", roic_hi, seq_on); end
  endtask

  task automatic test_rerequest;
    pwr_on_req = 1'b1;
    advance(21);
    checks++; if (seq_on !== 1'b1) begin errors++; $display("FAIL rr_on got=%b exp=1", seq_on); end
    advance(3);
    pwr_on_req = 1'b0;
    advance(3);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL rr_e3 got=%b exp=011", rail_en); end
    advance(5);
    checks++; if (rail_en !== 3'b001) begin errors++; $display("FAIL rr_e8 got=%b exp=001", rail_en); end
    pwr_on_req = 1'b1;
    advance(3);
    checks++; if (rail_en !== 3'b000 || seq_busy !== 1'b1) begin errors++; $display("FAIL rr_e11 got rail=%b busy=%b exp 000/1", rail_en, seq_busy); end
    advance(4);
    checks++; if ({rail_en, seq_busy, seq_on} !== 5'b00000) begin errors++; $display("FAIL rr_e15 got rail/busy/on=%b exp=00000", {rail_en, seq_busy, seq_on}); end
    advance(1);
    checks++; if (rail_en !== 3'b001 || seq_busy !== 1'b1) begin errors++; $display("FAIL rr_e16 got rail=%b busy=%b exp 001/1", rail_en, seq_busy); end
  endtask

  task automatic test_reset_mid;
    advance(4);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL rm_pre got=%b exp=011", rail_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (rail_en !== 3'b000 || init_rst !== 1'b1) begin errors++; $display("FAIL rm_async got rail=%b init=%b exp 000/1", rail_en, init_rst); end
    checks++; if ({roic_reset, seq_on, seq_busy, fault} !== 4'b0000) begin errors++; $display("FAIL rm_flags got=%b exp=0000", {roic_reset, seq_on, seq_busy, fault}); end
    advance(1);
    rst_n = 1'b1;
    advance(2);
    checks++; if (rail_en !== 3'b000) begin errors++; $display("FAIL rm_e2 got=%b exp=000", rail_en); end
    advance(1);
    checks++; if (rail_en !== 3'b001) begin errors++; $display("FAIL rm_e3 got=%b exp=001", rail_en); end
  endtask

`ifdef PWR_SEQ_PG_MONITOR_EN
  task automatic test_pg_fault;
    pwr_on_req = 1'b0;
    rst_n = 1'b0;
    advance(1);
    rst_n = 1'b1;
    pg_in = 3'b101;
    pwr_on_req = 1'b1;
    advance(7);
    checks++; if (rail_en !== 3'b011) begin errors++; $display("FAIL pg_e7 got=%b exp=011", rail_en); end
    advance(9);
    checks++; if (rail_en !== 3'b011 || fault !== 1'b0) begin errors++; $display("FAIL pg_e16 got rail=%b fault=%b exp 011/0", rail_en, fault); end
    advance(1);
    checks++; if ({rail_en, fault, seq_busy, seq_on} !== 5'b00010) begin errors++; $display("FAIL pg_e17 got rail/fault/busy/on=%b exp=00010", {rail_en, fault, seq_busy, seq_on}); end
    checks++; if (fault_step !== 2'd1) begin errors++; $display("FAIL pg_step got=%0d exp=1", fault_step); end
    fault_clr = 1'b1;
    advance(3);
    checks++; if (fault !== 1'b1 || rail_en !== 3'b000) begin errors++; $display("FAIL pg_clr_req got fault=%b rail=%b exp 1/000", fault, rail_en); end
    pwr_on_req = 1'b0;
    advance(2);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL pg_clr_e2 got=%b exp=1", fault); end
    advance(1);
    checks++; if (fault !== 1'b0 || fault_step !== 2'd1) begin errors++; $display("FAIL pg_clr_e3 got fault=%b step=%0d exp 0/1", fault, fault_step); end
    fault_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_rerequest();
    test_reset_mid();
`ifdef PWR_SEQ_PG_MONITOR_EN
    test_pg_fault();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
